// File: rtl/divvy_top_if.sv
// divvy_top_if: START/DONE handshake between the host and the divvy_top engine.
interface divvy_top_if;
    logic START;
    logic DONE;

    modport master (output START, input DONE);
    modport slave  (input START, output DONE);
endinterface

// File: rtl/divvy_top.sv
// divvy_top: arithmetic engine over a 256x8 data memory (instance MyDataMem).
// Each run executes the next program in rotation: P1 reciprocal, P2 16b/8b
// fixed-point divide, P3 integer square root. Results are written back and DONE raised.
// Optional build macro: CYCLE_COUNT_EN (start-to-done clock count written to M[30..31]).

module divvy_mem (
    input  logic       clk,
    input  logic       we,
    input  logic [7:0] waddr,
    input  logic [7:0] wdata,
    input  logic [7:0] raddr,
    output logic [7:0] rdata
);
    logic [7:0] MyMemory [0:255];

    // Byte write port; contents are not reset and are host-accessible hierarchically
    always_ff @(posedge clk) begin
        if (we) MyMemory[waddr] <= wdata;
    end

    assign rdata = MyMemory[raddr];
endmodule

module divvy_top (
    input logic        CLK,
    input logic        RESET_N,
    divvy_top_if.slave bus
);
    typedef enum logic [2:0] {IDLE, ARMED, RUN, WRITE, DONE_ST} state_t;
    typedef enum logic [1:0] {P1_RECIP, P2_DIV, P3_SQRT} prog_t;

`ifdef CYCLE_COUNT_EN
    localparam logic [2:0] CNT_BYTES = 3'd2;
    logic [15:0] cyc;
`else
    localparam logic [2:0] CNT_BYTES = 3'd0;
`endif

    state_t      state, state_nx;
    prog_t       prog;
    logic [6:0]  step;      // RUN sub-step: 0..2 load, 3 init, 4 iterate/finalize
    logic [6:0]  iter;
    logic [23:0] ld;        // operand bytes shifted in MS byte first
    logic [63:0] dvd;       // dividend, consumed MSB first
    logic [63:0] quo;
    logic [15:0] dsr;
    logic [16:0] rem;
    logic [16:0] sq_op, sq_res, sq_one;
    logic        zero_div;
    logic [23:0] res;       // result left-aligned, written MS byte first
    logic [2:0]  widx;

    logic [16:0] rem_sh;
    logic        div_ge;
    logic [16:0] sq_try;
    logic        sq_ge;
    logic [15:0] r16;
    logic [23:0] r24;
    logic [8:0]  r9;
    logic [23:0] res_nx;
    logic [6:0]  iter_last;
    logic        run_done;

    logic [7:0]  rd_base, wr_base, mem_raddr, mem_rdata, mem_waddr, mem_wdata;
    logic [2:0]  nres, nwr;
    logic        wr_last, mem_we;

    divvy_mem MyDataMem (
        .clk   (CLK),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .raddr (mem_raddr),
        .rdata (mem_rdata)
    );

    // Datapath step logic and final result rounding/saturation
    always_comb begin
        rem_sh    = {rem[15:0], dvd[63]};
        div_ge    = (rem_sh >= {1'b0, dsr});
        sq_try    = sq_res + sq_one;
        sq_ge     = (sq_op >= sq_try);
        r16       = quo[63:48] + {15'h0, quo[47]};
        r24       = quo[63:40] + {23'h0, quo[39]};
        r9        = {1'b0, sq_res[7:0]} + {8'h0, (sq_op > sq_res)};
        iter_last = (prog == P3_SQRT) ? 7'd8 : 7'd64;
        run_done  = (state == RUN) && (step == 7'd4) && (iter == iter_last);
        case (prog)
            P1_RECIP: res_nx = zero_div ? 24'hFFFF00 : {r16, 8'h00};
            P2_DIV:   res_nx = zero_div ? 24'hFFFFFF : r24;
            default:  res_nx = {(r9[8] ? 8'hFF : r9[7:0]), 16'h0000};
        endcase
    end

    // Memory port addressing: operand fetch during RUN, result bytes during WRITE
    always_comb begin
        case (prog)
            P1_RECIP: begin rd_base = 8'd8;  wr_base = 8'd10; nres = 3'd2; end
            P2_DIV:   begin rd_base = 8'd0;  wr_base = 8'd4;  nres = 3'd3; end
            default:  begin rd_base = 8'd16; wr_base = 8'd18; nres = 3'd1; end
        endcase
        nwr       = nres + CNT_BYTES;
        wr_last   = (widx == nwr - 3'd1);
        mem_raddr = rd_base + {6'h0, step[1:0]};
        mem_we    = (state == WRITE);
        mem_waddr = wr_base;
        mem_wdata = '0;
        if (widx < nres) begin
            mem_waddr = wr_base + {5'h0, widx};
            case (widx)
                3'd0:    mem_wdata = res[23:16];
                3'd1:    mem_wdata = res[15:8];
                default: mem_wdata = res[7:0];
            endcase
        end
`ifdef CYCLE_COUNT_EN
        else if (widx == nres) begin
            mem_waddr = 8'd30;
            mem_wdata = cyc[15:8];
        end else begin
            mem_waddr = 8'd31;
            mem_wdata = cyc[7:0];
        end
`endif
    end

    // FSM state register
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) state <= IDLE;
        else          state <= state_nx;
    end

    // FSM next-state: arm on START high, run on START fall, hold DONE until next START
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.START)  state_nx = ARMED;
            ARMED:   if (!bus.START) state_nx = RUN;
            RUN:     if (run_done)   state_nx = WRITE;
            WRITE:   if (wr_last)    state_nx = DONE_ST;
            DONE_ST: if (bus.START)  state_nx = ARMED;
            default:                 state_nx = IDLE;
        endcase
    end

    assign bus.DONE = (state == DONE_ST);

    // Operand load, shift-subtract divide / bitwise sqrt iteration, write sequencing, rotation
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            prog     <= P1_RECIP;
            step     <= '0;
            iter     <= '0;
            ld       <= '0;
            dvd      <= '0;
            quo      <= '0;
            dsr      <= '0;
            rem      <= '0;
            sq_op    <= '0;
            sq_res   <= '0;
            sq_one   <= '0;
            zero_div <= 1'b0;
            res      <= '0;
            widx     <= '0;
        end else begin
            case (state)
                ARMED: begin
                    step <= '0;
                    iter <= '0;
                    widx <= '0;
                end
                RUN: begin
                    if (step < 7'd3) begin
                        ld   <= {ld[15:0], mem_rdata};
                        step <= step + 7'd1;
                    end else if (step == 7'd3) begin
                        // P1 divides 2^63 by a 16b operand, P2 divides a<<48 by an 8b one
                        dsr      <= (prog == P1_RECIP) ? ld[23:8] : {8'h00, ld[7:0]};
                        dvd      <= (prog == P1_RECIP) ? 64'h8000_0000_0000_0000 : {ld[23:8], 48'h0};
                        zero_div <= (prog == P1_RECIP) ? (ld[23:8] == 16'h0) : (ld[7:0] == 8'h0);
                        rem      <= '0;
                        quo      <= '0;
                        sq_op    <= {1'b0, ld[23:8]};
                        sq_res   <= '0;
                        sq_one   <= 17'h04000;
                        iter     <= '0;
                        step     <= 7'd4;
                    end else if (iter != iter_last) begin
                        rem    <= div_ge ? (rem_sh - {1'b0, dsr}) : rem_sh;
                        quo    <= {quo[62:0], div_ge};
                        dvd    <= {dvd[62:0], 1'b0};
                        sq_op  <= sq_ge ? (sq_op - sq_try) : sq_op;
                        sq_res <= sq_ge ? ((sq_res >> 1) + sq_one) : (sq_res >> 1);
                        sq_one <= sq_one >> 2;
                        iter   <= iter + 7'd1;
                    end else begin
                        res <= res_nx;
                    end
                end
                WRITE: begin
                    widx <= widx + 3'd1;
                    if (wr_last) begin
                        case (prog)
                            P1_RECIP: prog <= P2_DIV;
                            P2_DIV:   prog <= P3_SQRT;
                            default:  prog <= P1_RECIP;
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef CYCLE_COUNT_EN
    // Clocks spent from START fall through result write-back
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)                            cyc <= '0;
        else if (state == ARMED)                 cyc <= '0;
        else if (state == RUN || state == WRITE) cyc <= cyc + 16'd1;
    end
`endif
endmodule

// File: tb/tb_divvy_top.sv
// tb_divvy_top: scoreboard bench for divvy_top; build with +define+CYCLE_COUNT_EN
// to also exercise the cycle-count bytes.
module tb_divvy_top;
    logic CLK;
    logic RESET_N;

    divvy_top_if bus ();

    divvy_top dut (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .bus     (bus)
    );

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
    } exp_t;

    exp_t       sbq [$];
    logic [7:0] img  [0:31];
    logic [7:0] expi [0:31];
    int         checks = 0;
    int         errors = 0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [15:0] m_p1(input logic [15:0] d);
        logic [63:0] q;
        if (d == 16'h0) return 16'hFFFF;
        q = 64'h8000_0000_0000_0000 / {48'h0, d};
        return q[63:48] + {15'h0, q[47]};
    endfunction

    function automatic logic [23:0] m_p2(input logic [15:0] a, input logic [7:0] b);
        logic [63:0] q;
        if (b == 8'h0) return 24'hFFFFFF;
        q = {a, 48'h0} / {56'h0, b};
        return q[63:40] + {23'h0, q[39]};
    endfunction

    function automatic logic [7:0] m_p3(input logic [15:0] x);
        int unsigned r = 0;
        int unsigned xv = x;
        while ((r + 1) * (r + 1) <= xv) r++;
        if (xv - r * r > r) r++;
        if (r > 255) r = 255;
        return 8'(r);
    endfunction

    task automatic load_pattern();
        for (int i = 0; i < 32; i++) img[i] = 8'($urandom);
    endtask

    task automatic commit_image();
        for (int i = 0; i < 32; i++) begin
            dut.MyDataMem.MyMemory[i] = img[i];
            expi[i] = img[i];
        end
    endtask

    task automatic push_expected();
        for (int i = 0; i < 32; i++) begin
`ifdef CYCLE_COUNT_EN
            if (i == 30 || i == 31) continue;
`endif
            sbq.push_back('{8'(i), expi[i]});
        end
    endtask

    task automatic run_prog(input string tag);
        int unsigned n;
        bit          seen;
        exp_t        e;
        logic [7:0]  got;
        @(negedge CLK);
        bus.START = 1'b1;
        @(negedge CLK);
        checks++;
        if (bus.DONE !== 1'b0) begin
            errors++;
            $display("FAIL %s done_clear: DONE=%b expected 0", tag, bus.DONE);
        end
        @(negedge CLK);
        bus.START = 1'b0;
        n = 0;
        seen = 1'b0;
        while (n < 200 && !seen) begin
            @(negedge CLK);
            n++;
            if (bus.DONE === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen || n > 150) begin
            errors++;
            $display("FAIL %s done_latency: seen=%0d cycles=%0d expected DONE within 150", tag, seen, n);
        end
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            got = dut.MyDataMem.MyMemory[e.addr];
            checks++;
            if (got !== e.data) begin
                errors++;
                $display("FAIL %s mem[%0d]: got %h expected %h", tag, e.addr, got, e.data);
            end
        end
`ifdef CYCLE_COUNT_EN
        begin
            logic [15:0] cnt;
            cnt = {dut.MyDataMem.MyMemory[30], dut.MyDataMem.MyMemory[31]};
            checks++;
            if (cnt == 16'h0 || cnt > 16'd150) begin
                errors++;
                $display("FAIL %s cycle_count: got %0d expected 1..150", tag, cnt);
            end
        end
`endif
        repeat (3) @(negedge CLK);
        checks++;
        if (bus.DONE !== 1'b1) begin
            errors++;
            $display("FAIL %s done_hold: DONE=%b expected 1", tag, bus.DONE);
        end
    endtask

    task automatic do_p1(input logic [15:0] d);
        logic [15:0] r;
        load_pattern();
        img[8] = d[15:8];
        img[9] = d[7:0];
        commit_image();
        r = m_p1(d);
        expi[10] = r[15:8];
        expi[11] = r[7:0];
        push_expected();
        run_prog("p1");
    endtask

    task automatic do_p2(input logic [15:0] a, input logic [7:0] b);
        logic [23:0] r;
        load_pattern();
        img[0] = a[15:8];
        img[1] = a[7:0];
        img[2] = b;
        commit_image();
        r = m_p2(a, b);
        expi[4] = r[23:16];
        expi[5] = r[15:8];
        expi[6] = r[7:0];
        push_expected();
        run_prog("p2");
    endtask

    task automatic do_p3(input logic [15:0] x);
        load_pattern();
        img[16] = x[15:8];
        img[17] = x[7:0];
        commit_image();
        expi[18] = m_p3(x);
        push_expected();
        run_prog("p3");
    endtask

    task automatic test_reset();
        RESET_N   = 1'b0;
        bus.START = 1'b0;
        repeat (3) @(negedge CLK);
        checks++;
        if (bus.DONE !== 1'b0) begin
            errors++;
            $display("FAIL reset_done: DONE=%b expected 0", bus.DONE);
        end
        RESET_N = 1'b1;
        repeat (3) @(negedge CLK);
        checks++;
        if (bus.DONE !== 1'b0) begin
            errors++;
            $display("FAIL idle_done: DONE=%b expected 0", bus.DONE);
        end
    endtask

    // Six rounds of P1,P2,P3; the rotation makes the 4th run a P1 again
    task automatic test_programs();
        logic [15:0] p1_d [0:5];
        logic [15:0] p2_a [0:5];
        logic [7:0]  p2_b [0:5];
        logic [15:0] p3_x [0:5];
        p1_d = '{16'h0001, 16'h0003, 16'h0000, 16'hFFFF, 16'h0100, 16'h0000};
        p2_a = '{16'h0001, 16'h0001, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000};
        p2_b = '{8'h03, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00};
        p3_x = '{16'd0, 16'd2, 16'd3, 16'd12, 16'd13, 16'd65535};
        p1_d[5] = 16'($urandom);
        for (int i = 3; i < 6; i++) begin
            p2_a[i] = 16'($urandom);
            p2_b[i] = 8'($urandom_range(1, 255));
        end
        for (int i = 0; i < 6; i++) begin
            do_p1(p1_d[i]);
            do_p2(p2_a[i], p2_b[i]);
            do_p3(p3_x[i]);
        end
    endtask

    task automatic test_reset_mid_run();
        do_p1(16'h0007);
        load_pattern();
        img[0] = 8'h12;
        img[1] = 8'h34;
        img[2] = 8'h05;
        commit_image();
        @(negedge CLK);
        bus.START = 1'b1;
        repeat (2) @(negedge CLK);
        bus.START = 1'b0;
        repeat (30) @(negedge CLK);
        RESET_N = 1'b0;
        #1;
        checks++;
        if (bus.DONE !== 1'b0) begin
            errors++;
            $display("FAIL midrst_done: DONE=%b expected 0", bus.DONE);
        end
        repeat (3) @(negedge CLK);
        RESET_N = 1'b1;
        repeat (150) @(negedge CLK);
        for (int i = 4; i < 7; i++) begin
            checks++;
            if (dut.MyDataMem.MyMemory[i] !== img[i]) begin
                errors++;
                $display("FAIL midrst_mem[%0d]: got %h expected %h", i, dut.MyDataMem.MyMemory[i], img[i]);
            end
        end
        checks++;
        if (bus.DONE !== 1'b0) begin
            errors++;
            $display("FAIL midrst_idle: DONE=%b expected 0", bus.DONE);
        end
        do_p1(16'h0005);
    endtask

    initial begin
        RESET_N   = 1'b0;
        bus.START = 1'b0;
        test_reset();
        test_programs();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
